// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD requester.
package gcd_pkg;

  localparam int unsigned GcdWidthDefault = 32;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StAck,
    StWait,
    StResp
  } gcd_state_e;

endpackage

// File: rtl/gcd_watchdog.sv
// Cycle watchdog: counts enabled cycles and flags expiry once the limit is reached.
module gcd_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count_q, count_d;

  // Saturates at the limit so expire stays asserted until cleared.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != Limit)) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && (count_q == Limit);

endmodule

// File: rtl/gcd_requester.sv
// Request/response front end for a start/done GCD engine.
// Optional watchdog abort enabled by defining GCD_TIMEOUT_EN.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH          = GcdWidthDefault,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_timeout,
  output logic             gcd_reset,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  input  logic [WIDTH-1:0] gcd_result,
  input  logic             gcd_done
);

  if (TIMEOUT_CYCLES == 0) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q;
  logic             expire;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StIssue;
      StIssue: state_d = StAck;
      // Engine done may still be high from the previous operation here.
      StAck:   state_d = StWait;
      StWait:  if (gcd_done || expire) state_d = StResp;
      StResp:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && in_valid) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (state_q == StWait) begin
        if (gcd_done) begin
          result_q <= gcd_result;
        end else if (expire) begin
          result_q <= '0;
        end
      end
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StResp);
  assign gcd_start  = (state_q == StIssue);
  assign gcd_a      = a_q;
  assign gcd_b      = b_q;
  assign out_result = result_q;

`ifdef GCD_TIMEOUT_EN
  logic timeout_q;
  logic abort_q;

  gcd_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (state_q == StIssue),
    .enable ((state_q == StAck) || (state_q == StWait)),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      abort_q <= (state_q == StWait) && !gcd_done && expire;
      if (state_q == StWait) begin
        if (gcd_done) begin
          timeout_q <= 1'b0;
        end else if (expire) begin
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign out_timeout = timeout_q;
  assign gcd_reset   = ~reset_n | abort_q;
`else
  assign expire      = 1'b0;
  assign out_timeout = 1'b0;
  assign gcd_reset   = ~reset_n;
`endif

endmodule

// File: tb/tb_gcd_requester.sv
// Bench pairing gcd_requester with a behavioural GCD engine and a result scoreboard.
module tb_gcd_requester;

  localparam int unsigned Width = 32;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] in_a;
  logic [Width-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] out_result;
  logic             out_timeout;
  logic             gcd_reset;
  logic             gcd_start;
  logic [Width-1:0] gcd_a;
  logic [Width-1:0] gcd_b;
  logic [Width-1:0] gcd_result;
  logic             gcd_done;

  gcd_requester #(
    .WIDTH         (Width),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_timeout(out_timeout),
    .gcd_reset  (gcd_reset),
    .gcd_start  (gcd_start),
    .gcd_a      (gcd_a),
    .gcd_b      (gcd_b),
    .gcd_result (gcd_result),
    .gcd_done   (gcd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine: registers start, loads operands a cycle later, Euclid step per cycle.
  logic             eng_start_q;
  logic             eng_busy;
  logic             eng_done;
  logic [Width-1:0] eng_x, eng_y;
  logic             stuck;

  always @(posedge clk) begin
    if (gcd_reset) begin
      eng_start_q <= 1'b0;
      eng_busy    <= 1'b0;
      eng_done    <= 1'b0;
      eng_x       <= '0;
      eng_y       <= '0;
    end else begin
      eng_start_q <= gcd_start;
      if (eng_start_q) begin
        eng_x    <= gcd_a;
        eng_y    <= gcd_b;
        eng_busy <= 1'b1;
        eng_done <= 1'b0;
      end else if (eng_busy) begin
        if (eng_y == 0) begin
          eng_busy <= 1'b0;
          eng_done <= 1'b1;
        end else begin
          eng_x <= eng_y;
          eng_y <= eng_x % eng_y;
        end
      end
    end
  end

  assign gcd_result = eng_x;
  assign gcd_done   = eng_done && !stuck;

  int n_checks = 0;
  int n_fails  = 0;
  int n_resp   = 0;
  int n_start  = 0;
  int n_abort  = 0;
  logic [Width:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [Width-1:0] ref_gcd(input logic [Width-1:0] a, input logic [Width-1:0] b);
    logic [Width-1:0] x = a;
    logic [Width-1:0] y = b;
    logic [Width-1:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Scoreboard side: sampled on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (reset_n) begin
      if (gcd_start) n_start++;
      if (gcd_reset) n_abort++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 1, 0);
        end else begin
          logic [Width:0] e;
          e = exp_q.pop_front();
          check("out_result", 64'(out_result), 64'(e[Width-1:0]));
          check("out_timeout", 64'(out_timeout), 64'(e[Width]));
        end
        n_resp++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [Width-1:0] a, input logic [Width-1:0] b, input bit timed_out);
    int k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    check("send_in_ready", 64'(in_ready), 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    exp_q.push_back(timed_out ? {1'b1, {Width{1'b0}}} : {1'b0, ref_gcd(a, b)});
    tick();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  task automatic wait_resp(input int budget);
    int r0 = n_resp;
    int k  = 0;
    while (n_resp == r0 && k < budget) begin
      check("busy_in_ready", 64'(in_ready), 0);
      tick();
      k++;
    end
    if (n_resp == r0) check("resp_timeout", 0, 1);
  endtask

  initial begin
    int s0;
    int k;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    stuck     = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_timeout", 64'(out_timeout), 0);
    check("rst_gcd_start", 64'(gcd_start), 0);
    check("rst_gcd_reset", 64'(gcd_reset), 1);
    check("rst_out_result", 64'(out_result), 0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("run_gcd_reset", 64'(gcd_reset), 0);

    // 12,8 -> 4 with a single start pulse
    s0 = n_start;
    send(12, 8, 1'b0);
    wait_resp(60);
    check("start_pulses", 64'(n_start - s0), 1);
    check("idle_after_resp", 64'(in_ready), 1);

    // Back-to-back zero operands; second must not reuse the stale done
    send(0, 7, 1'b0);
    wait_resp(60);
    send(9, 0, 1'b0);
    wait_resp(60);
    send(0, 0, 1'b0);
    wait_resp(60);

    // Backpressure: result held stable while out_ready is low
    out_ready = 1'b0;
    send(48, 18, 1'b0);
    k = 0;
    while (!out_valid && k < 60) begin
      tick();
      k++;
    end
    check("bp_reached_valid", 64'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 64'(out_valid), 1);
      check("bp_out_result", 64'(out_result), 6);
      check("bp_in_ready", 64'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    wait_resp(10);
    check("bp_idle_after", 64'(in_ready), 1);

    // Reset during WAIT discards the operation
    s0 = n_resp;
    send(1000, 3, 1'b0);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 0);
    check("mid_rst_out_result", 64'(out_result), 0);
    check("mid_rst_in_ready", 64'(in_ready), 1);
    check("mid_rst_gcd_reset", 64'(gcd_reset), 1);
    check("mid_rst_gcd_a", 64'(gcd_a), 0);
    check("mid_rst_gcd_start", 64'(gcd_start), 0);
    void'(exp_q.pop_back());
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    check("mid_rst_no_resp", 64'(n_resp - s0), 0);
    send(21, 14, 1'b0);
    wait_resp(60);

    // Engine never finishes
    stuck = 1'b1;
`ifdef GCD_TIMEOUT_EN
    s0 = n_abort;
    send(5, 10, 1'b1);
    wait_resp(40);
    check("abort_pulses", 64'(n_abort - s0), 1);
    stuck = 1'b0;
`else
    send(5, 10, 1'b0);
    for (int i = 0; i < 40; i++) begin
      check("stuck_no_valid", 64'(out_valid), 0);
      tick();
    end
    void'(exp_q.pop_back());
    reset_n = 1'b0;
    stuck   = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
`endif
    send(35, 14, 1'b0);
    wait_resp(60);
    check("sb_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/gcd_requester.md
GCD_REQUESTER -- requirements
Module: gcd_requester

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, watchdog limit in cycles (used only with GCD_TIMEOUT_EN).
REQ-003 SHALL have ports, clock and reset first:
  clk  in  1  single clock, all state on rising edge
  reset_n  in  1  asynchronous, active-low reset
  in_valid  in  1  operand pair offered
  in_ready  out  1  block can accept operand pair
  in_a  in  WIDTH  operand a
  in_b  in  WIDTH  operand b
  out_valid  out  1  result available
  out_ready  in  1  consumer accepts result
  out_result  out  WIDTH  gcd(in_a,in_b), or 0 on timeout
  out_timeout  out  1  result produced by watchdog abort
  gcd_reset  out  1  active-high reset to gcd engine
  gcd_start  out  1  start request to gcd engine
  gcd_a  out  WIDTH  operand a to engine
  gcd_b  out  WIDTH  operand b to engine
  gcd_result  in  WIDTH  engine result
  gcd_done  in  1  engine done (level; cleared by engine only on accepted start)

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, ACK, WAIT, RESP.
REQ-005 in_ready SHALL be 1 only in IDLE; in_valid&&in_ready latches in_a/in_b into operand registers, IDLE->ISSUE.
REQ-006 gcd_a/gcd_b SHALL be driven from operand registers at all times.
REQ-007 gcd_start SHALL be 1 for exactly one cycle, in ISSUE only; ISSUE->ACK unconditionally.
REQ-008 ACK SHALL last exactly one cycle and ignore gcd_done (stale done from previous operation); ACK->WAIT.
REQ-009 In WAIT, gcd_done=1 SHALL capture gcd_result into out_result, clear out_timeout, WAIT->RESP.
REQ-010 In RESP, out_valid SHALL be 1 with out_result/out_timeout stable; out_valid&&out_ready -> IDLE, in_ready=1 next cycle.
REQ-011 out_valid SHALL be 0 in all states except RESP; no new operand accepted before result handshake completes (one operation in flight).
REQ-012 Zero operands SHALL be passed through unmodified; gcd(0,0) returns engine result 0.
REQ-013 Minimum in-accept to out_valid latency SHALL be 4 cycles (IDLE accept, ISSUE, ACK, WAIT with done).

Reset
REQ-014 reset_n low SHALL asynchronously force IDLE, operand registers 0, out_result 0, out_valid 0, out_timeout 0, gcd_start 0, watchdog count 0.
REQ-015 gcd_reset SHALL equal ~reset_n OR abort pulse, so engine is reset whenever the requester is; reset mid-operation discards the operation with no output.

Configuration
REQ-016 With GCD_TIMEOUT_EN defined: counter counts cycles in ACK/WAIT; on reaching TIMEOUT_CYCLES without gcd_done, gcd_reset SHALL pulse 1 cycle, out_result=0, out_timeout=1, ->RESP; counter clears on entering ISSUE.
REQ-017 Without GCD_TIMEOUT_EN: no counter; WAIT persists until gcd_done; out_timeout tied 0; gcd_reset = ~reset_n.

Structure
REQ-018 Package gcd_pkg SHALL hold the FSM state enum and default WIDTH constant.
REQ-019 Watchdog SHALL be sub-module gcd_watchdog (clear, enable, expire), instantiated only under GCD_TIMEOUT_EN.

Verification (bench pairs block with the gcd engine)
REQ-020 a=12,b=8, out_ready=1 -> out_result=4, out_timeout=0, one gcd_start pulse, in_ready low until result accepted.
REQ-021 a=0,b=7 then a=9,b=0 back-to-back -> results 7 then 9; second result not the stale 7 (ACK skip verified).
REQ-022 a=48,b=18, out_ready held 0 for 10 cycles -> out_valid and out_result=6 stable throughout; accepted on release, IDLE next cycle.
REQ-023 reset_n dropped during WAIT for a=1000,b=3 -> all outputs 0 immediately, gcd_reset=1; after release next op a=21,b=14 -> 7.
REQ-024 GCD_TIMEOUT_EN, TIMEOUT_CYCLES=4, gcd_done forced 0 -> one-cycle gcd_reset pulse, out_result=0, out_timeout=1; macro off -> out_valid never asserts.
